uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning HCLK cycles per UART bit (legal values are 4 or more, even).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (legal values are powers of 2, from 2 to 256).
REQ-003 SHALL have port HCLK  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx  input  1  serial line, 8N1 format, idle high, asynchronous to HCLK.
REQ-006 SHALL have port en  input  1  receiver enable.
REQ-007 SHALL have port rd_data  output  8  byte at the FIFO head.
REQ-008 SHALL have port rd_valid  output  1  FIFO not empty.
REQ-009 SHALL have port rd_ready  input  1  consumer pop request.
REQ-010 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-011 SHALL have port frame_err  output  1  sticky framing-error flag.
REQ-012 SHALL have port overrun  output  1  sticky overrun flag.
REQ-013 SHALL have port err_clr  input  1  clears both sticky flags.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer whose flops reset to 1; all rx decisions SHALL use the synchronized value.
REQ-015 SHALL implement FSM states IDLE, START, DATA and STOP, with a bit counter (0..7) and a baud counter (0..CLKS_PER_BIT-1).
REQ-016 SHALL move IDLE->START when en=1 and the synchronized rx falls from 1 to 0; when en=0 the FSM SHALL stay in IDLE.
REQ-017 SHALL sample in START at CLKS_PER_BIT/2 cycles after the edge; a sample of 1 SHALL be treated as a glitch (->IDLE, nothing pushed), and a sample of 0 SHALL move the FSM to DATA.
REQ-018 SHALL sample each data bit in DATA at CLKS_PER_BIT-cycle intervals, LSB first, and move to STOP after bit 7.
REQ-019 SHALL sample in STOP after CLKS_PER_BIT cycles; sample=1 SHALL push the byte, sample=0 SHALL discard it and set frame_err; both cases SHALL then go to IDLE.
REQ-020 SHALL make a pushed byte visible on rd_data/rd_valid on the first cycle after the stop-bit sample cycle.
REQ-021 SHALL present the FIFO head combinationally on rd_data (first-word fall-through) whenever rd_valid=1.
REQ-022 SHALL pop when rd_valid=1 and rd_ready=1; rd_ready while empty SHALL be ignored and leave level unchanged.
REQ-023 SHALL accept a push when the FIFO is full and a pop occurs in the same cycle, leaving level unchanged.
REQ-024 SHALL, on a push while full without a same-cycle pop, drop the new byte, leave FIFO contents unchanged and set overrun.
REQ-025 SHALL wrap read and write pointers modulo FIFO_DEPTH, with an extra MSB distinguishing full from empty.
REQ-026 SHALL give set priority over err_clr when a set and err_clr coincide in the same cycle.
REQ-027 SHALL let a receiver deasserting en mid-frame finish the current frame; en is sampled only in IDLE.

Reset
REQ-028 SHALL, on HRESETn=0, immediately force state=IDLE, both counters=0, pointers=0, level=0, rd_valid=0, frame_err=0, overrun=0 and synchronizer=1.
REQ-029 SHALL drive rd_data=8'h00 while the FIFO is empty after reset.
REQ-030 SHALL abandon a frame in progress when reset asserts mid-frame; that frame is never pushed.
REQ-031 SHALL release reset synchronously to HCLK, provided by the SoC reset synchronizer.

Structure
REQ-032 SHALL take the UART state encoding typedef and the 8N1 frame constants (DATA_BITS=8, STOP_BITS=1) from the shared package n5_uart_pkg.
REQ-033 SHALL use one sub-module, n5_sync_fifo (parameterized width/depth, FWFT), with the FSM and synchronizer in the top module.

Verification
REQ-034 SHALL have the bench send 0x41 at CLKS_PER_BIT=16 -> rd_valid=1 with rd_data=0x41 one cycle after the stop sample; level=1.
REQ-035 SHALL have the bench pulse rx low for 4 cycles -> no push, state back to IDLE, level=0.
REQ-036 SHALL have the bench send 0x55 with the stop bit driven 0 -> frame_err=1, level=0; err_clr pulse -> frame_err=0.
REQ-037 SHALL have the bench send 17 bytes 0x00..0x10 with rd_ready=0 -> level=16, overrun=1, popped sequence 0x00..0x0F.
REQ-038 SHALL have the bench, with the FIFO full, assert rd_ready in the push cycle of a 17th byte 0xAA -> level stays 16, overrun=0, 0xAA last out.
REQ-039 SHALL have the bench assert HRESETn=0 during bit 3 of 0x3C -> all outputs at reset values, and a following 0x3C is received correctly.

Source files
------------

// File: rtl/n5_uart_pkg.sv
// ---------------------------------------------------------------------------
// n5_uart_pkg : UART receiver state encoding and 8N1 frame constants
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package n5_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 1;
   localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

endpackage

`default_nettype wire

// File: rtl/n5_sync_fifo.sv
// ---------------------------------------------------------------------------
// n5_sync_fifo : single-clock first-word-fall-through FIFO
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module n5_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     full,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             empty;
   logic             push;
   logic             pop;

   // Pointers carry one extra MSB so equal indices can mean either full or empty.
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop      = rd_en && !empty;
      push     = wr_en && (!full || pop);
      wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
      rd_valid = !empty;
      rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
      level    = wr_ptr_q - rd_ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo : 8N1 UART receiver feeding a FWFT receive FIFO
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo
   import n5_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          HCLK,
   input  logic                          HRESETn,
   input  logic                          rx,
   input  logic                          en,
   output logic [7:0]                    rd_data,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          err_clr
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [1:0]           sync_q, sync_d;
   logic                 rx_prev_q, rx_prev_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 rx_s;
   logic                 push;
   logic                 ferr_set;
   logic                 ovr_set;
   logic                 fifo_full;

   always_comb begin
      sync_d    = {sync_q[0], rx};
      rx_s      = sync_q[1];
      rx_prev_d = rx_s;

      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      push     = 1'b0;
      ferr_set = 1'b0;

      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (en && rx_prev_q && !rx_s) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (baud_q == BAUD_MID) begin
               baud_d  = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + BIT_W'(1);
               if (bit_q == BIT_LAST) begin
                  state_d = ST_STOP;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d   = '0;
               state_d  = ST_IDLE;
               push     = rx_s;
               ferr_set = !rx_s;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A same-cycle pop frees the slot, so only a push into a full FIFO with no pop is lost.
      ovr_set     = push && fifo_full && !(rd_valid && rd_ready);
      frame_err_d = ferr_set || (frame_err_q && !err_clr);
      overrun_d   = ovr_set  || (overrun_q   && !err_clr);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         sync_q      <= 2'b11;
         rx_prev_q   <= 1'b1;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         sync_q      <= sync_d;
         rx_prev_q   <= rx_prev_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

   n5_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (HCLK),
      .rst_n    (HRESETn),
      .wr_en    (push),
      .wr_data  (shift_q),
      .full     (fifo_full),
      .rd_en    (rd_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .level    (level)
   );

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo : directed, table-driven bench for uart_rx_fifo
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_fifo;
   import n5_uart_pkg::*;

   localparam int CPB   = 16;
   localparam int DEPTH = 16;
   localparam int LVL_W = $clog2(DEPTH) + 1;
   // Frame start (rx falls at a negedge) to stop-sample edge: 2 sync + 1 edge + 8 + 8*16 + 16.
   localparam int PUSH_CYC = 155;

   logic             HCLK = 1'b0;
   logic             HRESETn;
   logic             rx;
   logic             en;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic             rd_ready;
   logic [LVL_W-1:0] level;
   logic             frame_err;
   logic             overrun;
   logic             err_clr;

   int n_chk  = 0;
   int n_fail = 0;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .rx        (rx),
      .en        (en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .level     (level),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_clr   (err_clr)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_level;
      logic       exp_ferr;
      int         exp_rise;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one 8N1 frame; rise_cyc is the first sampled cycle where level grew (-1 if never).
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input logic pop_at_push, input logic clr_at_push,
                             output int rise_cyc);
      logic [9:0] frame;
      int prev_lvl;
      frame    = {stop_bit, b, 1'b0};
      rise_cyc = -1;
      @(negedge HCLK);
      rx       = 1'b0;
      prev_lvl = int'(level);
      for (int c = 1; c <= 160; c++) begin
         @(posedge HCLK);
         #1;
         if (rise_cyc < 0 && int'(level) > prev_lvl) rise_cyc = c;
         prev_lvl = int'(level);
         @(negedge HCLK);
         rx       = (c < 160) ? frame[c/16] : 1'b1;
         rd_ready = pop_at_push && (c == PUSH_CYC - 1);
         err_clr  = clr_at_push && (c == PUSH_CYC - 1);
      end
      repeat (4) @(negedge HCLK);
   endtask

   task automatic pop_exp(input logic [7:0] exp, input string nm);
      @(posedge HCLK);
      #1;
      chk({nm, " rd_valid"}, int'(rd_valid), 1);
      chk({nm, " rd_data"}, int'(rd_data), int'(exp));
      @(negedge HCLK);
      rd_ready = 1'b1;
      @(negedge HCLK);
      rd_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge HCLK);
      err_clr = 1'b1;
      @(negedge HCLK);
      err_clr = 1'b0;
   endtask

   initial begin
      int rise;
      logic [9:0] frame;

      vecs[0] = '{8'h41, 1'b1, 1, 1'b0, PUSH_CYC};
      vecs[1] = '{8'h55, 1'b0, 0, 1'b1, -1};
      vecs[2] = '{8'h00, 1'b1, 1, 1'b0, PUSH_CYC};
      vecs[3] = '{8'hFF, 1'b1, 1, 1'b0, PUSH_CYC};
      vecs[4] = '{8'h80, 1'b1, 1, 1'b0, PUSH_CYC};
      vecs[5] = '{8'h01, 1'b1, 1, 1'b0, PUSH_CYC};
      vecs[6] = '{8'hA5, 1'b0, 0, 1'b1, -1};
      vecs[7] = '{8'h3C, 1'b1, 1, 1'b0, PUSH_CYC};

      HRESETn  = 1'b0;
      rx       = 1'b1;
      en       = 1'b1;
      rd_ready = 1'b0;
      err_clr  = 1'b0;
      #1;
      chk("reset rd_valid", int'(rd_valid), 0);
      chk("reset rd_data", int'(rd_data), 0);
      chk("reset level", int'(level), 0);
      chk("reset frame_err", int'(frame_err), 0);
      chk("reset overrun", int'(overrun), 0);
      chk("reset state", int'(dut.state_q), int'(ST_IDLE));
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      repeat (3) @(negedge HCLK);

      for (int i = 0; i < NV; i++) begin
         send_frame(vecs[i].data, vecs[i].stop, 1'b0, 1'b0, rise);
         chk($sformatf("v%0d level", i), int'(level), vecs[i].exp_level);
         chk($sformatf("v%0d frame_err", i), int'(frame_err), int'(vecs[i].exp_ferr));
         chk($sformatf("v%0d overrun", i), int'(overrun), 0);
         chk($sformatf("v%0d push cycle", i), rise, vecs[i].exp_rise);
         if (vecs[i].exp_level == 1) begin
            pop_exp(vecs[i].data, $sformatf("v%0d pop", i));
            chk($sformatf("v%0d level after pop", i), int'(level), 0);
         end
         if (vecs[i].exp_ferr) begin
            pulse_clr();
            chk($sformatf("v%0d frame_err cleared", i), int'(frame_err), 0);
         end
      end

      // Glitch on rx shorter than half a bit
      @(negedge HCLK);
      rx = 1'b0;
      repeat (4) @(negedge HCLK);
      rx = 1'b1;
      repeat (20) @(negedge HCLK);
      chk("glitch state", int'(dut.state_q), int'(ST_IDLE));
      chk("glitch level", int'(level), 0);
      chk("glitch frame_err", int'(frame_err), 0);

      // Receiver disabled ignores a whole frame
      en = 1'b0;
      send_frame(8'h12, 1'b1, 1'b0, 1'b0, rise);
      chk("disabled level", int'(level), 0);
      chk("disabled push", rise, -1);
      en = 1'b1;

      // err_clr coinciding with a framing error: set wins
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, rise);
      chk("set beats clr frame_err", int'(frame_err), 1);
      pulse_clr();
      chk("frame_err cleared again", int'(frame_err), 0);

      // Fill, then one byte too many
      for (int i = 0; i < 17; i++) begin
         send_frame(8'(i), 1'b1, 1'b0, 1'b0, rise);
         if (i == 15) chk("fill level 16", int'(level), 16);
         if (i == 15) chk("fill no overrun", int'(overrun), 0);
      end
      chk("overflow level", int'(level), 16);
      chk("overflow overrun", int'(overrun), 1);
      for (int i = 0; i < 16; i++) pop_exp(8'(i), $sformatf("drain%0d", i));
      chk("drained level", int'(level), 0);
      chk("drained rd_valid", int'(rd_valid), 0);

      // rd_ready while empty has no effect
      @(negedge HCLK);
      rd_ready = 1'b1;
      repeat (3) @(negedge HCLK);
      rd_ready = 1'b0;
      chk("empty pop level", int'(level), 0);
      chk("empty rd_data", int'(rd_data), 0);
      pulse_clr();
      chk("overrun cleared", int'(overrun), 0);

      // Full FIFO with a pop in the push cycle
      for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1, 1'b0, 1'b0, rise);
      chk("refill level", int'(level), 16);
      send_frame(8'hAA, 1'b1, 1'b1, 1'b0, rise);
      chk("push+pop full level", int'(level), 16);
      chk("push+pop full overrun", int'(overrun), 0);
      for (int i = 1; i < 16; i++) pop_exp(8'(8'h20 + i), $sformatf("pp%0d", i));
      pop_exp(8'hAA, "pp last");
      chk("pp drained level", int'(level), 0);

      // Reset during bit 3 of a frame, with stale contents and flags
      send_frame(8'h66, 1'b0, 1'b0, 1'b0, rise);
      send_frame(8'h77, 1'b1, 1'b0, 1'b0, rise);
      chk("pre-reset level", int'(level), 1);
      chk("pre-reset frame_err", int'(frame_err), 1);
      frame = {1'b1, 8'h3C, 1'b0};
      @(negedge HCLK);
      rx = 1'b0;
      for (int c = 1; c <= 72; c++) begin
         @(negedge HCLK);
         rx = frame[c/16];
      end
      chk("mid-frame state", int'(dut.state_q), int'(ST_DATA));
      HRESETn = 1'b0;
      #1;
      chk("mid reset rd_valid", int'(rd_valid), 0);
      chk("mid reset rd_data", int'(rd_data), 0);
      chk("mid reset level", int'(level), 0);
      chk("mid reset frame_err", int'(frame_err), 0);
      chk("mid reset overrun", int'(overrun), 0);
      chk("mid reset state", int'(dut.state_q), int'(ST_IDLE));
      chk("mid reset bit cnt", int'(dut.bit_q), 0);
      chk("mid reset baud cnt", int'(dut.baud_q), 0);
      rx = 1'b1;
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      repeat (100) @(negedge HCLK);
      chk("abandoned frame level", int'(level), 0);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, rise);
      chk("post-reset push cycle", rise, PUSH_CYC);
      chk("post-reset level", int'(level), 1);
      pop_exp(8'h3C, "post-reset pop");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
